// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: holds the instruction register and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, with a memory-wait timeout.

package cpu_types_pkg;
    typedef enum logic [5:0] {
        RTYPE = 6'h00, J     = 6'h02, JAL   = 6'h03, BEQ   = 6'h04,
        BNE   = 6'h05, ADDI  = 6'h08, ADDIU = 6'h09, SLTI  = 6'h0A,
        SLTIU = 6'h0B, ANDI  = 6'h0C, ORI   = 6'h0D, XORI  = 6'h0E,
        LUI   = 6'h0F, LW    = 6'h23, SW    = 6'h2B, HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'h00, SRL  = 6'h02, JR   = 6'h08, ADD  = 6'h20,
        ADDU = 6'h21, SUB  = 6'h22, SUBU = 6'h23, AND  = 6'h24,
        OR   = 6'h25, XOR  = 6'h26, NOR  = 6'h27, SLT  = 6'h2A,
        SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3,
        ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
        ALU_SLT = 4'd8, ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module mc_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int COUNT_W     = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WORD_W-1:0]  imemload,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               zero,
    output logic               iREN,
    output logic               dREN,
    output logic               dWEN,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [2:0]         PCsrc,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic               MemtoReg,
    output logic [1:0]         ALUsrc,
    output aluop_t             aluop,
    output logic               lui,
    output logic [WORD_W-1:0]  instr,
    output logic               halt,
    output logic               bus_err,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALTED = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    localparam logic [2:0] PC_NPC  = 3'd0;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_JUMP = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;
    localparam logic [2:0] PC_BEQ  = 3'd5;

    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int              LIMIT_I    = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(LIMIT_I);

    logic [2:0]        state, next;
    logic [WAIT_W-1:0] wait_cnt;
    opcode_t           op;
    funct_t            fn;
    logic              legal;
    logic              timed_out;
    logic              retire;

    assign op        = opcode_t'(instr[31:26]);
    assign fn        = funct_t'(instr[5:0]);
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);
    assign retire    = (next == FETCH) &&
                       (state == DECODE || state == EXEC || state == MEM || state == WB);

    always_comb begin
        legal = 1'b0;
        case (op)
            J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU,
            ANDI, ORI, XORI, LUI, LW, SW, HALT: legal = 1'b1;
            RTYPE: begin
                case (fn)
                    SLL, SRL, JR, ADD, ADDU, SUB, SUBU,
                    AND, OR, XOR, NOR, SLT, SLTU: legal = 1'b1;
                    default:                      legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next     = state;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCsrc    = PC_NPC;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        MemtoReg = 1'b0;
        ALUsrc   = 2'd0;
        aluop    = ALU_SLL;
        lui      = 1'b0;
        illegal  = 1'b0;

        case (state)
            FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    next    = DECODE;
                end else if (timed_out) begin
                    next = ERROR;
                end
            end

            DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    next    = FETCH;
                end else begin
                    case (op)
                        HALT: next = HALTED;
                        J: begin
                            PCWrite = 1'b1;
                            PCsrc   = PC_JUMP;
                            next    = FETCH;
                        end
                        JAL: begin
                            PCWrite  = 1'b1;
                            PCsrc    = PC_JUMP;
                            RegWrite = 1'b1;
                            RegDst   = 2'd2;
                            next     = FETCH;
                        end
                        default: next = EXEC;
                    endcase
                end
            end

            EXEC: begin
                next = WB;
                case (op)
                    RTYPE: begin
                        case (fn)
                            SLL:        begin aluop = ALU_SLL; ALUsrc = 2'd1; end
                            SRL:        begin aluop = ALU_SRL; ALUsrc = 2'd1; end
                            SUB, SUBU:  aluop = ALU_SUB;
                            AND:        aluop = ALU_AND;
                            OR:         aluop = ALU_OR;
                            XOR:        aluop = ALU_XOR;
                            NOR:        aluop = ALU_NOR;
                            SLT:        aluop = ALU_SLT;
                            SLTU:       aluop = ALU_SLTU;
                            default:    aluop = ALU_ADD;
                        endcase
                        if (fn == JR) begin
                            PCWrite = 1'b1;
                            PCsrc   = PC_JR;
                            next    = FETCH;
                        end
                    end
                    // Branches compare two registers, so the ALU keeps rdat2.
                    BEQ: begin
                        aluop   = ALU_SUB;
                        PCWrite = zero;
                        PCsrc   = PC_BEQ;
                        next    = FETCH;
                    end
                    BNE: begin
                        aluop   = ALU_SUB;
                        PCWrite = !zero;
                        PCsrc   = PC_BNE;
                        next    = FETCH;
                    end
                    ANDI:   begin aluop = ALU_AND;  ALUsrc = 2'd3; end
                    ORI:    begin aluop = ALU_OR;   ALUsrc = 2'd3; end
                    XORI:   begin aluop = ALU_XOR;  ALUsrc = 2'd3; end
                    SLTI:   begin aluop = ALU_SLT;  ALUsrc = 2'd2; end
                    SLTIU:  begin aluop = ALU_SLTU; ALUsrc = 2'd2; end
                    LW, SW: begin aluop = ALU_ADD;  ALUsrc = 2'd2; next = MEM; end
                    default: begin aluop = ALU_ADD; ALUsrc = 2'd2; end
                endcase
            end

            MEM: begin
                dREN = (op == LW);
                dWEN = (op != LW);
                if (dhit) begin
                    next = (op == LW) ? WB : FETCH;
                end else if (timed_out) begin
                    next = ERROR;
                end
            end

            WB: begin
                RegWrite = 1'b1;
                RegDst   = (op == RTYPE) ? 2'd1 : 2'd0;
                MemtoReg = (op == LW);
                lui      = (op == LUI);
                next     = FETCH;
            end

            HALTED, ERROR: next = state;

            default: next = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FETCH;
            instr       <= '0;
            halt        <= 1'b0;
            bus_err     <= 1'b0;
            instr_count <= '0;
            wait_cnt    <= '0;
        end else begin
            state <= next;
            if (IRWrite) instr <= imemload;
            if (next == HALTED) halt <= 1'b1;
            if (next == ERROR) bus_err <= 1'b1;
            if (retire) instr_count <= instr_count + 1'b1;
            if (next != state) begin
                wait_cnt <= '0;
            end else if (state == FETCH || state == MEM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule
